// File: rtl/multi_cycle_cpu.sv
// Multi-cycle MIPS-subset core with one unified memory port.
// Outputs are registered and are built from next-state values, so memReq stays low for one clock after reset.
module multi_cycle_cpu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32,
    parameter logic [5:0]  HALT_OP  = 6'h3F
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             memReq,
    output logic             memWe,
    output logic [31:0]      memAddr,
    output logic [31:0]      memWData,
    input  logic [31:0]      memRData,
    input  logic             memReady,
    output logic [31:0]      pc,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    state_t          state_r, state_nxt_s;
    logic [31:0]     pc_r, pc_nxt_s;
    logic [31:0]     ir_r;
    logic [31:0]     a_r, b_r, tgt_r, alu_r, mdr_r;
    logic [CNT_W-1:0] retired_r;
    logic            halted_r, illegal_r;
    logic            mem_req_r, mem_we_r;
    logic [31:0]     mem_addr_r, mem_wdata_r;
    logic [31:0]     rf_r [32];

    logic            mem_req_nxt_s, mem_we_nxt_s;
    logic [31:0]     mem_addr_nxt_s, mem_wdata_nxt_s;
    logic            ir_ld_s, dec_ld_s, alu_ld_s, mdr_ld_s;
    logic            retire_s, halt_s, illegal_s;
    logic            rf_we_s;
    logic [4:0]      rf_waddr_s;
    logic [31:0]     rf_wdata_s;
    logic [31:0]     alu_res_s;
    logic            mem_done_s;

    logic [5:0]      op_s, funct_s;
    logic [4:0]      rs_s, rt_s, rd_s;
    logic [15:0]     imm_s;
    logic [31:0]     sext_s, zext_s, rs_val_s, rt_val_s;

    assign op_s     = ir_r[31:26];
    assign rs_s     = ir_r[25:21];
    assign rt_s     = ir_r[20:16];
    assign rd_s     = ir_r[15:11];
    assign funct_s  = ir_r[5:0];
    assign imm_s    = ir_r[15:0];
    assign sext_s   = {{16{imm_s[15]}}, imm_s};
    assign zext_s   = {16'h0000, imm_s};
    assign rs_val_s = (rs_s == 5'd0) ? 32'h0000_0000 : rf_r[rs_s];
    assign rt_val_s = (rt_s == 5'd0) ? 32'h0000_0000 : rf_r[rt_s];

    assign mem_done_s = mem_req_r & memReady;

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: ok = 1'b1;
                    default:                               ok = 1'b0;
                endcase
            end
            OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // ALU: logical immediates zero-extend, arithmetic and address immediates sign-extend
    always_comb begin
        alu_res_s = 32'h0000_0000;
        case (op_s)
            OP_RTYPE: begin
                case (funct_s)
                    FN_ADD:  alu_res_s = a_r + b_r;
                    FN_SUB:  alu_res_s = a_r - b_r;
                    FN_AND:  alu_res_s = a_r & b_r;
                    FN_OR:   alu_res_s = a_r | b_r;
                    FN_SLT:  alu_res_s = {31'd0, ($signed(a_r) < $signed(b_r))};
                    default: alu_res_s = 32'h0000_0000;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: alu_res_s = a_r + sext_s;
            OP_ANDI:               alu_res_s = a_r & zext_s;
            OP_ORI:                alu_res_s = a_r | zext_s;
            default:               alu_res_s = 32'h0000_0000;
        endcase
    end

    // Next-state and datapath strobes
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        ir_ld_s     = 1'b0;
        dec_ld_s    = 1'b0;
        alu_ld_s    = 1'b0;
        mdr_ld_s    = 1'b0;
        retire_s    = 1'b0;
        halt_s      = 1'b0;
        illegal_s   = 1'b0;
        rf_we_s     = 1'b0;
        rf_waddr_s  = 5'd0;
        rf_wdata_s  = 32'h0000_0000;
        case (state_r)
            ST_FETCH: begin
                if (mem_done_s) begin
                    ir_ld_s     = 1'b1;
                    pc_nxt_s    = pc_r + 32'd4;
                    state_nxt_s = ST_DECODE;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                dec_ld_s = 1'b1;
                if (op_s == HALT_OP) begin
                    halt_s      = 1'b1;
                    state_nxt_s = ST_HALT;
                end else if (!is_legal(op_s, funct_s)) begin
                    halt_s      = 1'b1;
                    illegal_s   = 1'b1;
                    state_nxt_s = ST_HALT;
                end else if (op_s == OP_J) begin
                    pc_nxt_s    = {pc_r[31:28], ir_r[25:0], 2'b00};
                    retire_s    = 1'b1;
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (op_s)
                    OP_BEQ, OP_BNE: begin
                        pc_nxt_s    = ((a_r == b_r) == (op_s == OP_BEQ)) ? tgt_r : pc_r;
                        retire_s    = 1'b1;
                        state_nxt_s = ST_FETCH;
                    end
                    OP_LW, OP_SW: begin
                        alu_ld_s    = 1'b1;
                        state_nxt_s = ST_MEM;
                    end
                    OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI: begin
                        alu_ld_s    = 1'b1;
                        state_nxt_s = ST_WB;
                    end
                    default: begin
                        halt_s      = 1'b1;
                        illegal_s   = 1'b1;
                        state_nxt_s = ST_HALT;
                    end
                endcase
            end
            ST_MEM: begin
                if (mem_done_s && (op_s == OP_SW)) begin
                    retire_s    = 1'b1;
                    state_nxt_s = ST_FETCH;
                end else if (mem_done_s) begin
                    mdr_ld_s    = 1'b1;
                    state_nxt_s = ST_WB;
                end else begin
                    state_nxt_s = ST_MEM;
                end
            end
            ST_WB: begin
                rf_we_s     = 1'b1;
                retire_s    = 1'b1;
                state_nxt_s = ST_FETCH;
                if (op_s == OP_RTYPE) begin
                    rf_waddr_s = rd_s;
                    rf_wdata_s = alu_r;
                end else if (op_s == OP_LW) begin
                    rf_waddr_s = rt_s;
                    rf_wdata_s = mdr_r;
                end else begin
                    rf_waddr_s = rt_s;
                    rf_wdata_s = alu_r;
                end
            end
            ST_HALT: begin
                state_nxt_s = ST_HALT;
            end
            default: begin
                halt_s      = 1'b1;
                illegal_s   = 1'b1;
                state_nxt_s = ST_HALT;
            end
        endcase
    end

    // Memory port values for the coming cycle; data accesses drop the low address bits
    always_comb begin
        mem_req_nxt_s   = 1'b0;
        mem_we_nxt_s    = 1'b0;
        mem_addr_nxt_s  = 32'h0000_0000;
        mem_wdata_nxt_s = 32'h0000_0000;
        if (state_nxt_s == ST_FETCH) begin
            mem_req_nxt_s  = 1'b1;
            mem_addr_nxt_s = pc_nxt_s;
        end else if (state_nxt_s == ST_MEM) begin
            mem_req_nxt_s   = 1'b1;
            mem_we_nxt_s    = (op_s == OP_SW);
            mem_addr_nxt_s  = (state_r == ST_EXEC) ? {alu_res_s[31:2], 2'b00}
                                                   : {alu_r[31:2], 2'b00};
            mem_wdata_nxt_s = (op_s == OP_SW) ? b_r : 32'h0000_0000;
        end else begin
            mem_req_nxt_s = 1'b0;
        end
    end

    // Control state, datapath latches, counters and registered memory port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_FETCH;
            pc_r        <= RESET_PC;
            ir_r        <= 32'h0000_0000;
            a_r         <= 32'h0000_0000;
            b_r         <= 32'h0000_0000;
            tgt_r       <= 32'h0000_0000;
            alu_r       <= 32'h0000_0000;
            mdr_r       <= 32'h0000_0000;
            retired_r   <= '0;
            halted_r    <= 1'b0;
            illegal_r   <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= RESET_PC;
            mem_wdata_r <= 32'h0000_0000;
        end else begin
            state_r     <= state_nxt_s;
            pc_r        <= pc_nxt_s;
            mem_req_r   <= mem_req_nxt_s;
            mem_we_r    <= mem_we_nxt_s;
            mem_addr_r  <= mem_addr_nxt_s;
            mem_wdata_r <= mem_wdata_nxt_s;
            if (ir_ld_s) begin
                ir_r <= memRData;
            end
            if (dec_ld_s) begin
                a_r   <= rs_val_s;
                b_r   <= rt_val_s;
                tgt_r <= pc_r + (sext_s << 2);
            end
            if (alu_ld_s) begin
                alu_r <= alu_res_s;
            end
            if (mdr_ld_s) begin
                mdr_r <= memRData;
            end
            if (retire_s) begin
                retired_r <= retired_r + CNT_W'(1);
            end
            if (halt_s) begin
                halted_r <= 1'b1;
            end
            if (illegal_s) begin
                illegal_r <= 1'b1;
            end
        end
    end

    // Register file is not reset; register 0 is never written
    always_ff @(posedge clk) begin
        if (rf_we_s && (rf_waddr_s != 5'd0)) begin
            rf_r[rf_waddr_s] <= rf_wdata_s;
        end
    end

    assign memReq   = mem_req_r;
    assign memWe    = mem_we_r;
    assign memAddr  = mem_addr_r;
    assign memWData = mem_wdata_r;
    assign pc       = pc_r;
    assign halted   = halted_r;
    assign illegal  = illegal_r;
    assign retired  = retired_r;

endmodule
